// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Conditions a raw, bouncing push-button for the stopwatch counter.
// The button is synchronised, debounced and each press is classified as
// short (start/stop) or long (clear).
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   btn           raw push-button, asynchronous, active-high, may bounce
//   btn_db        debounced button level
//   toggle_pulse  one-cycle pulse when a short press completes
//   clear_pulse   one-cycle pulse when a press becomes long
//   running       start/stop level, drives the counter's count enable
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before btn_db changes (>= 2)
//   LONG_CYCLES      debounced-pressed cycles that make a press long
//                    (> DEBOUNCE_CYCLES)
// ---------------------------------------------------------------------------
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LONG_CYCLES     = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic btn_db,
   output logic toggle_pulse,
   output logic clear_pulse,
   output logic running
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } state_t;

   logic              sync1_r;
   logic              sync2_r;
   logic              btn_db_r;
   logic [DB_W-1:0]   db_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_nxt_s;
   logic              toggle_r;
   logic              toggle_nxt_s;
   logic              clear_r;
   logic              clear_nxt_s;
   logic              running_r;
   logic              running_nxt_s;
   state_t            state_r;
   state_t            next_state_s;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: btn_db follows sync2 only after DEBOUNCE_CYCLES stable cycles;
   // any return to the current level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_db_r <= 1'b0;
         db_cnt_r <= '0;
      end else if (sync2_r == btn_db_r) begin
         db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
         btn_db_r <= sync2_r;
         db_cnt_r <= '0;
      end else begin
         db_cnt_r <= db_cnt_r + DB_W'(1);
      end
   end

   // Press-classification FSM state, hold counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         hold_cnt_r <= '0;
         toggle_r   <= 1'b0;
         clear_r    <= 1'b0;
         running_r  <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         toggle_r   <= toggle_nxt_s;
         clear_r    <= clear_nxt_s;
         running_r  <= running_nxt_s;
      end
   end

   // Next-state and next-output logic. Release is checked before the long
   // threshold, so a toggle and a clear can never coincide. hold_cnt stops
   // at HOLD_LAST because HELD is left on that value, so it cannot wrap.
   always_comb begin
      next_state_s   = state_r;
      hold_cnt_nxt_s = hold_cnt_r;
      toggle_nxt_s   = 1'b0;
      clear_nxt_s    = 1'b0;
      running_nxt_s  = running_r;
      case (state_r)
         IDLE: begin
            if (btn_db_r) begin
               next_state_s   = HELD;
               hold_cnt_nxt_s = '0;
            end else begin
               next_state_s   = IDLE;
            end
         end
         HELD: begin
            if (!btn_db_r) begin
               next_state_s  = IDLE;
               toggle_nxt_s  = 1'b1;
               running_nxt_s = ~running_r;
            end else if (hold_cnt_r == HOLD_LAST) begin
               next_state_s  = LONG;
               clear_nxt_s   = 1'b1;
               running_nxt_s = 1'b0;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         LONG: begin
            if (!btn_db_r) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = LONG;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   assign btn_db       = btn_db_r;
   assign toggle_pulse = toggle_r;
   assign clear_pulse  = clear_r;
   assign running      = running_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner with default parameters
// (DEBOUNCE_CYCLES=16, LONG_CYCLES=200). Inputs change 1 time unit after a
// rising edge, so the next rising edge is the one where sync1 captures them
// ("edge 0"). Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic btn_db;
   logic toggle_pulse;
   logic clear_pulse;
   logic running;

   int total = 0;
   int fails = 0;
   int tog_cnt = 0;
   int clr_cnt = 0;
   int both_cnt = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   logic prev_db = 1'b0;

   btn_conditioner dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .btn_db       (btn_db),
      .toggle_pulse (toggle_pulse),
      .clear_pulse  (clear_pulse),
      .running      (running)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance n rising edges, sampling outputs 1 unit after each edge.
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (toggle_pulse) tog_cnt++;
         if (clear_pulse) clr_cnt++;
         if (toggle_pulse && clear_pulse) both_cnt++;
         if (btn_db && !prev_db) rise_cnt++;
         if (!btn_db && prev_db) fall_cnt++;
         prev_db = btn_db;
      end
   endtask

   task automatic clear_counts();
      tog_cnt  = 0;
      clr_cnt  = 0;
      both_cnt = 0;
      rise_cnt = 0;
      fall_cnt = 0;
   endtask

   // Button high for n capture edges, so btn_db is high for exactly n cycles.
   task automatic press(input int n);
      btn = 1'b1;
      run(n);
      btn = 1'b0;
      run(40);
   endtask

   initial begin
      // ---- reset state ----
      run(3);
      check("rst_btn_db", btn_db, 0);
      check("rst_toggle", toggle_pulse, 0);
      check("rst_clear", clear_pulse, 0);
      check("rst_running", running, 0);
      rst_n = 1'b1;
      clear_counts();
      run(100);
      check("idle_toggles", tog_cnt, 0);
      check("idle_clears", clr_cnt, 0);

      // ---- glitch rejection: 10-cycle pulse ----
      clear_counts();
      btn = 1'b1;
      run(10);
      btn = 1'b0;
      run(40);
      check("glitch_rises", rise_cnt, 0);
      check("glitch_toggles", tog_cnt, 0);
      check("glitch_running", running, 0);

      // ---- clean short press, exact latencies ----
      clear_counts();
      btn = 1'b1;
      run(17);                       // edges 0..16
      check("short_db_edge16", btn_db, 0);
      run(1);                        // edge 17
      check("short_db_edge17", btn_db, 1);
      run(42);                       // edges 18..59
      btn = 1'b0;
      run(17);                       // release capture R .. R+16
      check("short_db_R16", btn_db, 1);
      check("short_no_early_toggle", tog_cnt, 0);
      run(1);                        // R+17: btn_db falls
      check("short_db_R17", btn_db, 0);
      check("short_toggle_R17", toggle_pulse, 0);
      run(1);                        // R+18: FSM sees release
      check("short_toggle_R18", toggle_pulse, 1);
      check("short_running_R18", running, 1);
      run(1);
      check("short_toggle_width", toggle_pulse, 0);
      run(30);
      check("short_toggle_count", tog_cnt, 1);
      check("short_clear_count", clr_cnt, 0);

      // ---- second identical press stops the counter ----
      clear_counts();
      press(60);
      check("short2_toggle_count", tog_cnt, 1);
      check("short2_running", running, 0);

      // ---- bouncy press ----
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         btn = ~btn;
         run(3);
      end
      btn = 1'b1;
      run(80);
      btn = 1'b0;
      run(40);
      check("bounce_rises", rise_cnt, 1);
      check("bounce_falls", fall_cnt, 1);
      check("bounce_toggles", tog_cnt, 1);
      check("bounce_clears", clr_cnt, 0);
      check("bounce_running", running, 1);

      // ---- long press from running=1 ----
      // btn_db rises at edge 17, HELD from edge 18, last hold_cnt increment
      // at edge 217, clear_pulse at edge 218.
      clear_counts();
      btn = 1'b1;
      run(18);                       // edges 0..17
      check("long_db_rise", btn_db, 1);
      run(200);                      // edges 18..217
      check("long_no_early_clear", clr_cnt, 0);
      check("long_running_before", running, 1);
      run(1);                        // edge 218
      check("long_clear_edge", clear_pulse, 1);
      check("long_running_cleared", running, 0);
      run(181);                      // total 400 cycles held
      btn = 1'b0;
      run(40);
      check("long_clear_count", clr_cnt, 1);
      check("long_toggle_count", tog_cnt, 0);
      check("long_running_after", running, 0);

      // ---- threshold boundary ----
      clear_counts();
      press(200);
      check("b200_toggles", tog_cnt, 1);
      check("b200_clears", clr_cnt, 0);
      check("b200_running", running, 1);
      clear_counts();
      press(201);
      check("b201_toggles", tog_cnt, 0);
      check("b201_clears", clr_cnt, 1);
      check("b201_running", running, 0);

      // ---- asynchronous reset mid-press with running=1 ----
      press(60);
      check("pre_rst_running", running, 1);
      btn = 1'b1;
      run(40);                       // btn_db high, FSM in HELD
      check("pre_rst_db", btn_db, 1);
      #3;
      rst_n = 1'b0;
      #1;                            // well before the next edge
      check("async_rst_db", btn_db, 0);
      check("async_rst_running", running, 0);
      check("async_rst_toggle", toggle_pulse, 0);
      check("async_rst_clear", clear_pulse, 0);
      btn = 1'b0;
      run(3);
      rst_n = 1'b1;
      clear_counts();
      prev_db = btn_db;
      run(100);
      check("post_rst_toggles", tog_cnt, 0);
      check("post_rst_clears", clr_cnt, 0);
      check("post_rst_running", running, 0);

      // pulses must never coincide anywhere in the run
      check("pulse_exclusive", both_cnt, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   // Hard bound on simulation time.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
